// File: rtl/single_sync_ram_pkg.sv
// rtl/single_sync_ram_pkg.sv - shared constants for the single-port synchronous RAM
package single_sync_ram_pkg;
    localparam int DEF_MEM_WIDTH = 16;
    localparam int DEF_MEM_DEPTH = 1024;
    localparam int DEF_ADDR_SIZE = 10;

    localparam int PIPE_OFF = 0;
    localparam int PIPE_ON  = 1;

    function automatic logic even_parity(input logic [DEF_MEM_WIDTH-1:0] word);
        return ^word;
    endfunction
endpackage

// File: rtl/single_sync_ram_sram_array.sv
// rtl/single_sync_ram_sram_array.sv - storage array with synchronous write and registered read
module single_sync_ram_sram_array
    import single_sync_ram_pkg::*;
#(
    parameter int MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [MEM_WIDTH-1:0] din,
    output logic [MEM_WIDTH-1:0] rd_q,
    output logic [MEM_WIDTH-1:0] rd_word
);
    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    // Contents survive reset; only the write is suppressed while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n && we)
            mem[addr] <= din;
    end

    assign rd_word = mem[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_q <= '0;
        else if (re)
            rd_q <= rd_word;
    end
endmodule

// File: rtl/single_sync_ram.sv
// rtl/single_sync_ram.sv - single-port synchronous RAM with optional address/output pipelines and parity
module single_sync_ram
    import single_sync_ram_pkg::*;
#(
    parameter int MEM_WIDTH     = DEF_MEM_WIDTH,
    parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE     = DEF_ADDR_SIZE,
    parameter int ADDR_PIPELINE = PIPE_OFF,
    parameter int DOUT_PIPELINE = PIPE_ON
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MEM_WIDTH-1:0] din,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 blk_select,
    input  logic                 addr_en,
    input  logic                 dout_en,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 parity_out
);
    logic [ADDR_SIZE-1:0] ea;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [MEM_WIDTH-1:0] rd_q;
    logic [MEM_WIDTH-1:0] rd_word;
    logic [MEM_WIDTH-1:0] out_src;
    logic                 do_wr;
    logic                 do_rd;

    // Write wins over a simultaneous read request.
    assign do_wr = blk_select && wr_en;
    assign do_rd = blk_select && rd_en && !wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            addr_q <= '0;
        else if (blk_select && addr_en)
            addr_q <= addr;
    end

    assign ea = (ADDR_PIPELINE == PIPE_ON) ? addr_q : addr;

    single_sync_ram_sram_array #(
        .MEM_WIDTH (MEM_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst),
        .we      (do_wr),
        .re      (do_rd),
        .addr    (ea),
        .din     (din),
        .rd_q    (rd_q),
        .rd_word (rd_word)
    );

    // Pipelined mode forwards the previous read stage; otherwise take the array word directly.
    assign out_src = (DOUT_PIPELINE == PIPE_ON) ? rd_q : rd_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            parity_out <= 1'b0;
        end else if (do_rd && dout_en) begin
            dout       <= out_src;
            parity_out <= ^out_src;
        end
    end
endmodule

// File: tb/tb_single_sync_ram.sv
// tb/tb_single_sync_ram.sv - directed self-checking bench for single_sync_ram
module tb_single_sync_ram;
    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [9:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic        blk_select;
    logic        addr_en;
    logic        dout_en;
    logic [15:0] dout;
    logic        parity_out;

    int n_cmp;
    int n_bad;

    logic [15:0] snap [1024];

    single_sync_ram dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .blk_select (blk_select),
        .addr_en    (addr_en),
        .dout_en    (dout_en),
        .dout       (dout),
        .parity_out (parity_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic w, input logic r, input logic de,
                         input logic [9:0] a, input logic [15:0] d);
        blk_select = b;
        wr_en      = w;
        rd_en      = r;
        dout_en    = de;
        addr       = a;
        din        = d;
    endtask

    initial begin
        logic [15:0] keep;
        int changed;
        logic [15:0] dout_hold;
        logic        par_hold;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        addr_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
        for (int i = 0; i < 1024; i++)
            dut.u_array.mem[i] = 16'(i * 3) ^ 16'h5A5A;
        #2;

        // Reset hold: writes blocked, outputs zero.
        for (int s = 0; s < 100; s++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom), 16'($urandom));
            addr_en = 1'($urandom);
            keep = dut.u_array.mem[addr];
            for (int c = 0; c < 3; c++) begin
                cyc(1);
                check("rst_dout", 32'(dout), 32'h0);
                check("rst_par", 32'(parity_out), 32'h0);
            end
            check("rst_mem", 32'(dut.u_array.mem[addr]), 32'(keep));
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
        addr_en = 1'b0;
        rst = 1'b1;
        cyc(1);
        check("post_rst_dout", 32'(dout), 32'h0);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 10'h005, 16'hA5A5);
        cyc(2);
        check("wr_mem5", 32'(dut.u_array.mem[5]), 32'hA5A5);

        drive(1'b1, 1'b0, 1'b1, 1'b1, 10'h005, 16'h0000);
        cyc(2);
        check("rd5_dout", 32'(dout), 32'hA5A5);
        check("rd5_par", 32'(parity_out), 32'h0);

        drive(1'b1, 1'b1, 1'b0, 1'b1, 10'h003, 16'h0001);
        cyc(2);
        check("wr_mem3", 32'(dut.u_array.mem[3]), 32'h0001);
        check("wr_dout_hold", 32'(dout), 32'hA5A5);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 10'h003, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            check("gate_dout", 32'(dout), 32'hA5A5);
            check("gate_par", 32'(parity_out), 32'h0);
        end
        dout_en = 1'b1;
        cyc(2);
        check("rd3_dout", 32'(dout), 32'h0001);
        check("rd3_par", 32'(parity_out), 32'h1);

        // Two-stage latency: first edge still presents the previous rd_q (addr 3).
        drive(1'b1, 1'b0, 1'b1, 1'b1, 10'h005, 16'h0000);
        cyc(1);
        check("lat_edge1", 32'(dout), 32'h0001);
        cyc(1);
        check("lat_edge2", 32'(dout), 32'hA5A5);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 10'h007, 16'h1234);
        cyc(1);
        check("wr_pri_mem7", 32'(dut.u_array.mem[7]), 32'h1234);
        check("wr_pri_dout", 32'(dout), 32'hA5A5);

        drive(1'b1, 1'b0, 1'b1, 1'b1, 10'h007, 16'h0000);
        cyc(2);
        check("rd7_dout", 32'(dout), 32'h1234);
        check("rd7_par", 32'(parity_out), 32'h1);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 10'h005, 16'hFFFF);
        cyc(3);
        check("nop_dout", 32'(dout), 32'h1234);

        // Block deselected: nothing moves.
        for (int i = 0; i < 1024; i++) snap[i] = dut.u_array.mem[i];
        dout_hold = dout;
        par_hold  = parity_out;
        for (int s = 0; s < 1000; s++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom), 16'($urandom));
            addr_en = 1'($urandom);
            cyc(1);
            check("blk_off_dout", 32'(dout), 32'(dout_hold));
        end
        check("blk_off_par", 32'(parity_out), 32'(par_hold));
        changed = 0;
        for (int i = 0; i < 1024; i++)
            if (dut.u_array.mem[i] !== snap[i]) changed++;
        check("blk_off_mem", 32'(changed), 32'h0);

        // Asynchronous reset mid-read clears outputs without a clock edge.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 10'h003, 16'h0000);
        cyc(1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout), 32'h0);
        check("async_rst_par", 32'(parity_out), 32'h0);
        check("async_rst_mem7", 32'(dut.u_array.mem[7]), 32'h1234);
        cyc(1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 10'h007, 16'h0000);
        cyc(1);
        check("deassert_edge1", 32'(dout), 32'h0);
        cyc(1);
        check("deassert_edge2", 32'(dout), 32'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
